// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_ctrl_pkg : shared states and constants for the duty sequencer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pwm_ctrl_pkg;

  localparam logic [9:0] PERIOD_MAX   = 10'h3FF;
  localparam logic [9:0] STEP_DEFAULT = 10'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_duty_sequencer_if : command, control and status bundle          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pwm_duty_sequencer_if;

  logic       cmd_valid;
  logic [9:0] cmd_duty;
  logic       cmd_ready;
  logic       estop;
  logic [9:0] duty_out;
  logic       pwm_out;
  logic       period_strobe;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_duty, estop,
    input  cmd_ready, duty_out, pwm_out, period_strobe, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_duty, estop,
    output cmd_ready, duty_out, pwm_out, period_strobe, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_core : 10-bit PWM edge generator driven by an external counter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pwm_core
  import pwm_ctrl_pkg::*;
(
  input  wire       clk,
  input  wire       rst_n,
  input  wire [9:0] counter,
  input  wire [9:0] duty,
  output logic      pwm
);

  // Set wins over clear so a duty of 1023 yields a constant high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else if (counter == PERIOD_MAX) begin
      pwm <= 1'b1;
    end else if (counter == duty) begin
      pwm <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_duty_sequencer : rate-limited duty ramping with emergency stop  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter logic [9:0] STEP = STEP_DEFAULT
) (
  input  wire                  clk,
  input  wire                  rst_n,
  pwm_duty_sequencer_if.slave  bus
);

  logic [9:0]         r_counter;
  logic [9:0]         r_duty;
  logic [9:0]         r_target;
  logic               r_done;
  seq_state_t         r_state;

  logic               w_strobe;
  logic               w_ready;
  logic               w_transfer;
  logic               w_core_pwm;
  logic signed [10:0] w_diff;
  logic [10:0]        w_abs;

  assign w_strobe   = (r_counter == PERIOD_MAX);
  assign w_ready    = ~bus.estop & (r_state != STOP);
  assign w_transfer = bus.cmd_valid & w_ready;

  // Eleven bits hold any signed distance between two 10-bit duties.
  assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_duty});
  assign w_abs  = w_diff[10] ? 11'(-w_diff) : 11'(w_diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= 10'd0;
    end else begin
      r_counter <= r_counter + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_duty   <= 10'd0;
      r_target <= 10'd0;
      r_done   <= 1'b0;
    end else if (bus.estop) begin
      r_state  <= STOP;
      r_duty   <= 10'd0;
      r_target <= 10'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RAMP: begin
          if (w_strobe) begin
            if (w_abs <= {1'b0, STEP}) begin
              r_duty  <= r_target;
              r_done  <= 1'b1;
              r_state <= HOLD;
            end else if (w_diff[10]) begin
              r_duty <= r_duty - STEP;
            end else begin
              r_duty <= r_duty + STEP;
            end
          end
        end
        STOP:    r_state <= IDLE;
        default: ;
      endcase
      // Placed last: a command landing on a boundary steps with the old
      // target above and still keeps (or returns) the sequencer in RAMP.
      if (w_transfer) begin
        r_target <= bus.cmd_duty;
        r_state  <= RAMP;
      end
    end
  end

  pwm_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .counter (r_counter),
    .duty    (r_duty),
    .pwm     (w_core_pwm)
  );

  assign bus.cmd_ready     = w_ready;
  assign bus.duty_out      = r_duty;
  assign bus.done          = r_done;
  assign bus.busy          = (r_state == RAMP);
  assign bus.period_strobe = w_strobe;
  assign bus.pwm_out       = w_core_pwm & ((r_state == RAMP) | (r_state == HOLD));

endmodule
`default_nettype wire
